// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store at a time over valid/ready, byte-lane RAM access,
// load extension. Optional macro DMEM_MISALIGN_SPLIT_EN splits misaligned half/word accesses.
module dmem_resp #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_type,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [30:0] DEPTH_W = 31'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    state_t state_q, state_d;

    logic          we_q, uns_q, err_q;
    logic [1:0]    type_q, off_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          accept, err_d;
    logic [29:0]   widx;
    logic [2:0]    nbytes;
    logic [3:0]    lane_en;
    logic [31:0]   lane_wd;
    logic [AW-1:0] acc_idx;
    logic          ram_we, ram_re;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   rd_q;
    logic [31:0]   lo_w, hi_w, al_w, ext_w;

    assign accept = req_valid & req_ready;
    assign widx   = req_addr[31:2];

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic        split_d, split_q;
    logic [30:0] widx_nx;
    logic [31:0] lo_q;
    assign widx_nx = {1'b0, widx} + 31'd1;
`endif

    // Request classification happens on the raw inputs so it can be latched at acceptance.
    always_comb begin
        err_d = (req_type == 2'b11) || ({1'b0, widx} >= DEPTH_W);
`ifdef DMEM_MISALIGN_SPLIT_EN
        split_d = ((req_type == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                  ((req_type == 2'b10) && (req_addr[1:0] != 2'b00));
        if (split_d && (widx_nx >= DEPTH_W)) err_d = 1'b1;
`else
        if (((req_type == 2'b01) && req_addr[0]) ||
            ((req_type == 2'b10) && (req_addr[1:0] != 2'b00))) err_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            type_q  <= 2'b00;
            off_q   <= 2'b00;
            idx_q   <= '0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= err_d;
            type_q  <= req_type;
            off_q   <= req_addr[1:0];
            idx_q   <= widx[AW-1:0];
            wdata_q <= req_wdata;
        end
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            split_q <= 1'b0;
            lo_q    <= 32'h0;
        end else begin
            if (accept) split_q <= split_d;
            if (state_q == ACC1) lo_q <= rd_q;
        end
    end
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = ACC0;
            ACC0: begin
                state_d = RESP;
`ifdef DMEM_MISALIGN_SPLIT_EN
                if (!err_q && split_q) state_d = ACC1;
`endif
            end
            ACC1: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (type_q)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // Each lane picks its source byte of wdata; out-of-range sources wrap above nbytes and disable the lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [2:0] src;
            assign src = (state_q == ACC1) ? (3'(gi) + 3'd4 - {1'b0, off_q})
                                           : (3'(gi) - {1'b0, off_q});
            assign lane_en[gi]        = (src < nbytes);
            assign lane_wd[gi*8 +: 8] = wdata_q[{src[1:0], 3'b000} +: 8];
        end
    endgenerate

    assign acc_idx = (state_q == ACC1) ? (idx_q + AW'(1)) : idx_q;
    assign ram_we  = ((state_q == ACC0) || (state_q == ACC1)) && we_q && !err_q && !rst;
    assign ram_re  = ((state_q == ACC0) || (state_q == ACC1)) && !we_q && !err_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_en[l]) mem_q[acc_idx][l*8 +: 8] <= lane_wd[l*8 +: 8];
            end
        end
        if (ram_re) rd_q <= mem_q[acc_idx];
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign lo_w = split_q ? lo_q : rd_q;
`else
    assign lo_w = rd_q;
`endif
    assign hi_w  = rd_q;
    assign al_w  = 32'({hi_w, lo_w} >> {off_q, 3'b000});

    always_comb begin
        case (type_q)
            2'b00:   ext_w = {{24{~uns_q & al_w[7]}}, al_w[7:0]};
            2'b01:   ext_w = {{16{~uns_q & al_w[15]}}, al_w[15:0]};
            default: ext_w = al_w;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) && err_q;
        rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? ext_w : 32'h0;
    end
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the RISC-V core: the memory-side end of the load/store path whose write enable, access size and signedness come from the core's control decoder. It accepts one load or store request at a time over a valid/ready handshake. It performs byte-lane-masked access to an internal word-organised RAM, sign- or zero-extends load data, and returns a single response per request over a second valid/ready handshake.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the RAM; power of two, ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_type` in 2: access size, encoded as funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_unsigned` in 1: funct3[2]; selects zero-extension for loads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: request rejected; no RAM state changed.

## Operation
- The FSM has four states: IDLE, ACC0, ACC1, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch all request fields.
  - Compute the error flag and split flag at acceptance, then go to ACC0.
- **Error conditions**
  - `req_type`=11.
  - Word index `addr[31:2]` ≥ DEPTH.
  - Split access whose second word index ≥ DEPTH. There is no wrap-around.
  - Misaligned access when the split feature is compiled out (see Configuration).
- **Split accesses** span two words:
  - half at `addr[1:0]`=3;
  - word at `addr[1:0]`≠0.
- **ACC0**
  - Access word `addr[31:2]`.
  - Stores write the enabled lanes only:
    - byte: lane `addr[1:0]`;
    - half: lanes `addr[1:0]` and `addr[1:0]+1` (limited to ≤3);
    - word: lanes from `addr[1:0]` to 3.
  - Loads register the word.
  - Next state is ACC1 if split, otherwise RESP.
  - If the error flag is set, no write is done and the FSM goes directly to RESP.
- **ACC1**
  - Access word `addr[31:2]+1`, lanes 0 up to the remaining byte count.
  - Store data is the upper remaining bytes of `req_wdata`.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until `rsp_valid & rsp_ready`, then the FSM returns to IDLE.
- **Load data assembly**
  - Bytes are gathered from ACC0 (and ACC1 if split) and right-aligned.
  - Byte loads extend bit 7 and half loads extend bit 15, zero-filled if `req_unsigned`=1.
  - Word loads are passed through unchanged.
- Requests are never queued; `req_ready`=0 in every state except IDLE.

## Timing
- **Reset values:** state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - RAM contents are not reset.
- **Reset mid-operation:** the FSM is forced to IDLE immediately.
  - A store write that completed on an earlier edge persists.
  - A write in the same cycle as `rst` assertion is not performed.
- **Latency:** with the request accepted at edge E0, `rsp_valid` rises after E1 (aligned or error) or after E2 (split).
- **Response hold:** the response is held for any number of `rsp_ready`=0 cycles.
- **Throughput:** one request per 3 cycles (4 if split) when `rsp_ready` is tied to 1.
  - `req_ready` rises in the cycle after the response handshake.
- **Read/write ordering:** a load following a store to the same address returns the stored data, since the write commits before the load's ACC0 edge.

## Configuration
- `DMEM_MISALIGN_SPLIT_EN` defined: misaligned half and word accesses are split across two words as described above, using the ACC1 state.
- Undefined: ACC1 is not implemented.
  - Any half access with `addr[0]`=1, or word access with `addr[1:0]`≠0, responds with `rsp_err`=1 and `rsp_rdata`=0.
  - No write is performed.

## Test plan
- **Reset:** assert `rst` for 2 cycles -> `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- **Word store/load:** store word 0xDEADBEEF to addr 0x10, then load word 0x10 -> `rsp_rdata`=0xDEADBEEF, `rsp_err`=0; `rsp_valid` rises 2 cycles after each acceptance.
- **Byte/half extension:** after the word above, perform:
  - load byte 0x13 signed -> 0xFFFFFFDE;
  - load byte 0x13 unsigned -> 0x000000DE;
  - load half 0x10 signed -> 0xFFFFBEEF;
  - store byte 0x55 to 0x11, then load word 0x10 -> 0xDEAD55EF.
- **Misaligned word:** store word 0x11223344 to 0x0E, then load word 0x0C and 0x10.
  - With the macro defined: loads return 0x3344xxxx and 0xxxxx1122 respectively, and load word 0x0E returns 0x11223344.
  - Without the macro: `rsp_err`=1 and memory is unchanged.
- **Out of range and reserved type:**
  - Load word at byte address 4·DEPTH -> `rsp_err`=1, `rsp_rdata`=0.
  - Store with `req_type`=11 -> `rsp_err`=1, and a subsequent load at the same address shows the old data.
- **Backpressure and reset:**
  - Hold `rsp_ready`=0 for 5 cycles -> `rsp_valid`, `rsp_rdata` stable and `req_ready`=0 throughout.
  - Assert `rst` during RESP -> `rsp_valid` drops asynchronously and `req_ready`=1.
